if_id_decode_stage: RTL and testbench

//  IF/ID pipeline register plus instruction decoder, directly downstream of instruction fetch.

---
 rtl/if_id_decode_stage_pkg.sv | 48 ++++
 rtl/if_id_decode_stage_if.sv | 37 +++
 rtl/if_id_decode_stage_classifier.sv | 27 ++
 rtl/if_id_decode_stage.sv | 149 ++++++++++++++
 tb/tb_if_id_decode_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/if_id_decode_stage_pkg.sv
// ===== cpu_isa_pkg : ISA opcodes, field positions, class/state enums =====
// Rev 1.0
`default_nettype none

package cpu_isa_pkg;

  localparam int PC_W   = 7;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 17;
  localparam int OPC_W  = 5;

  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 17;
  localparam int RS2_LSB = 12;

  localparam logic [OPC_W-1:0] OP_ADD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ADDI  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LOAD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_STORE = 5'b00101;
  localparam logic [OPC_W-1:0] OP_BEQ   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_JMP   = 5'b01001;
  localparam logic [OPC_W-1:0] OP_HALT  = 5'b01011;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_ALUI    = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_HALT    = 3'd5,
    CL_ILLEGAL = 3'd6
  } instr_class_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } stage_state_t;

  function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_decode_stage_if.sv
// ===== if_id_decode_stage_if : fetch-side inputs and decoded bundle =====
// Rev 1.0
`default_nettype none

interface if_id_decode_stage_if;
  import cpu_isa_pkg::*;

  logic [31:0]       instr_in;
  logic              done_in;
  logic              stall_in;
  logic              flush_in;
  logic              id_valid;
  logic [OPC_W-1:0]  id_opcode;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [31:0]       id_imm;
  logic [PC_W-1:0]   id_br_tgt;
  instr_class_t      id_class;
  logic              id_halted;
  logic              hazard_stall;

  modport master (
    output instr_in, done_in, stall_in, flush_in,
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_br_tgt,
           id_class, id_halted, hazard_stall
  );

  modport slave (
    input  instr_in, done_in, stall_in, flush_in,
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_imm, id_br_tgt,
           id_class, id_halted, hazard_stall
  );

endinterface

`default_nettype wire

// File: rtl/if_id_decode_stage_classifier.sv
// ===== instr_classifier : combinational opcode -> instruction class =====
// Rev 1.0
`default_nettype none

module instr_classifier
  import cpu_isa_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output instr_class_t     o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_opcode)
      OP_ADD, OP_SUB: o_class = CL_ALU;
      OP_ADDI:        o_class = CL_ALUI;
      OP_LOAD:        o_class = CL_LOAD;
      OP_STORE:       o_class = CL_STORE;
      OP_BEQ, OP_JMP: o_class = CL_BRANCH;
      OP_HALT:        o_class = CL_HALT;
      default:        o_class = CL_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/if_id_decode_stage.sv
// ===== if_id_decode_stage : IF/ID register, decoder, halt drain FSM =====
// Optional load-use hazard detection with HAZARD_DETECT_EN. Rev 1.0
`default_nettype none

module if_id_decode_stage
  import cpu_isa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  if_id_decode_stage_if.slave bus
);

  logic [OPC_W-1:0]  w_opcode;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  instr_class_t      w_class;
  logic              w_hazard;
  logic              w_load, w_clear, w_bubble;
  stage_state_t      r_state, w_state_nxt;

  logic              r_valid, r_halted;
  logic [OPC_W-1:0]  r_opcode;
  logic [REG_AW-1:0] r_rd, r_rs1, r_rs2;
  logic [31:0]       r_imm;
  logic [PC_W-1:0]   r_br_tgt;
  instr_class_t      r_class;

  assign w_opcode = bus.instr_in[OPC_LSB +: OPC_W];
  assign w_rd     = bus.instr_in[RD_LSB  +: REG_AW];
  assign w_rs1    = bus.instr_in[RS1_LSB +: REG_AW];
  assign w_rs2    = bus.instr_in[RS2_LSB +: REG_AW];

  instr_classifier u_classifier (
    .i_opcode (w_opcode),
    .o_class  (w_class)
  );

`ifdef HAZARD_DETECT_EN
  logic [REG_AW-1:0] r_prev_rd;
  logic              r_prev_is_load;

  // Only raised when the stage would otherwise capture, so it lasts one cycle.
  assign w_hazard = (r_state == ST_RUN) && !bus.flush_in && !bus.stall_in && !bus.done_in &&
                    r_prev_is_load && (r_prev_rd != '0) &&
                    ((w_rs1 == r_prev_rd) || (w_rs2 == r_prev_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_rd      <= '0;
      r_prev_is_load <= 1'b0;
    end else if (w_clear) begin
      r_prev_is_load <= 1'b0;
    end else if (w_load && (bus.instr_in != 32'h0)) begin
      r_prev_rd      <= w_rd;
      r_prev_is_load <= (w_opcode == OP_LOAD);
    end else if (w_hazard) begin
      r_prev_is_load <= 1'b0;
    end
  end
`else
  assign w_hazard = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.flush_in) begin
          w_clear = 1'b1;
        end else if (bus.stall_in) begin
          w_load = 1'b0;
        end else if (bus.done_in) begin
          w_bubble    = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (w_hazard) begin
          w_bubble = 1'b1;
        end else begin
          w_load = 1'b1;
        end
      end
      // A flush here means the halt came from a squashed path.
      ST_DRAIN: begin
        if (bus.flush_in) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_opcode <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_imm    <= '0;
      r_br_tgt <= '0;
      r_class  <= CL_ILLEGAL;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == ST_HALTED);
      if (w_clear) begin
        r_valid  <= 1'b0;
        r_opcode <= '0;
        r_rd     <= '0;
        r_rs1    <= '0;
        r_rs2    <= '0;
        r_imm    <= '0;
        r_br_tgt <= '0;
        r_class  <= CL_ILLEGAL;
      end else if (w_bubble) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid  <= (bus.instr_in != 32'h0);
        r_opcode <= w_opcode;
        r_rd     <= w_rd;
        r_rs1    <= w_rs1;
        r_rs2    <= w_rs2;
        r_imm    <= sext_imm(bus.instr_in[IMM_W-1:0]);
        r_br_tgt <= bus.instr_in[PC_W-1:0];
        r_class  <= w_class;
      end
    end
  end

  assign bus.id_valid     = r_valid;
  assign bus.id_opcode    = r_opcode;
  assign bus.id_rd        = r_rd;
  assign bus.id_rs1       = r_rs1;
  assign bus.id_rs2       = r_rs2;
  assign bus.id_imm       = r_imm;
  assign bus.id_br_tgt    = r_br_tgt;
  assign bus.id_class     = r_class;
  assign bus.id_halted    = r_halted;
  assign bus.hazard_stall = w_hazard;

endmodule

`default_nettype wire

// File: tb/tb_if_id_decode_stage.sv
// ===== tb_if_id_decode_stage : directed self-checking bench =====
// Rev 1.0
`default_nettype none

module tb_if_id_decode_stage;
  import cpu_isa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  if_id_decode_stage_if bus ();

  if_id_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr_in = 32'h0;
    bus.done_in  = 1'b0;
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;

    #12;
    chk("rst_valid",  32'(bus.id_valid), 32'd0);
    chk("rst_class",  32'(bus.id_class), 32'd6);
    chk("rst_imm",    bus.id_imm, 32'd0);
    chk("rst_halted", 32'(bus.id_halted), 32'd0);
    chk("rst_hazard", 32'(bus.hazard_stall), 32'd0);
    rst = 1'b0;

    bus.instr_in = 32'h10A3_5FFF;
    step();
    chk("cap_valid",  32'(bus.id_valid), 32'd1);
    chk("cap_opcode", 32'(bus.id_opcode), 32'd2);
    chk("cap_rd",     32'(bus.id_rd), 32'd2);
    chk("cap_rs1",    32'(bus.id_rs1), 32'd17);
    chk("cap_rs2",    32'(bus.id_rs2), 32'd21);
    chk("cap_imm",    bus.id_imm, 32'hFFFF_5FFF);
    chk("cap_brtgt",  32'(bus.id_br_tgt), 32'h7F);
    chk("cap_class",  32'(bus.id_class), 32'd1);

    bus.stall_in = 1'b1;
    bus.instr_in = 32'hF800_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_opcode", 32'(bus.id_opcode), 32'd2);
      chk("stall_valid",  32'(bus.id_valid), 32'd1);
    end
    bus.flush_in = 1'b1;
    step();
    chk("stflush_valid",  32'(bus.id_valid), 32'd0);
    chk("stflush_opcode", 32'(bus.id_opcode), 32'd0);
    chk("stflush_class",  32'(bus.id_class), 32'd6);
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;

    bus.instr_in = 32'h0;
    step();
    chk("nop_valid", 32'(bus.id_valid), 32'd0);

    bus.instr_in = 32'h00C2_2000;
    step();
    chk("add_valid", 32'(bus.id_valid), 32'd1);
    chk("add_class", 32'(bus.id_class), 32'd0);
    chk("add_rd",    32'(bus.id_rd), 32'd3);
    chk("add_rs1",   32'(bus.id_rs1), 32'd1);
    chk("add_rs2",   32'(bus.id_rs2), 32'd2);
    chk("add_imm",   bus.id_imm, 32'h0000_2000);

    bus.instr_in = 32'hF800_0000;
    step();
    chk("ill_valid",  32'(bus.id_valid), 32'd1);
    chk("ill_class",  32'(bus.id_class), 32'd6);
    chk("ill_opcode", 32'(bus.id_opcode), 32'd31);

    bus.instr_in = 32'h4000_0055;
    step();
    chk("beq_class", 32'(bus.id_class), 32'd4);
    chk("beq_brtgt", 32'(bus.id_br_tgt), 32'h55);

    bus.instr_in = 32'h2800_0000;
    step();
    chk("st_class", 32'(bus.id_class), 32'd3);

    bus.flush_in = 1'b1;
    step();
    chk("flush_valid", 32'(bus.id_valid), 32'd0);
    chk("flush_rd",    32'(bus.id_rd), 32'd0);

    // halt followed by a flush while draining
    bus.flush_in = 1'b0;
    bus.done_in  = 1'b1;
    bus.instr_in = 32'h5800_0000;
    step();
    chk("drn_valid",  32'(bus.id_valid), 32'd0);
    chk("drn_halted", 32'(bus.id_halted), 32'd0);
    bus.done_in  = 1'b0;
    bus.flush_in = 1'b1;
    bus.instr_in = 32'h0;
    step();
    chk("drnfl_valid",  32'(bus.id_valid), 32'd0);
    chk("drnfl_halted", 32'(bus.id_halted), 32'd0);
    bus.flush_in = 1'b0;
    bus.instr_in = 32'h00C2_2000;
    step();
    chk("rerun_valid",  32'(bus.id_valid), 32'd1);
    chk("rerun_rd",     32'(bus.id_rd), 32'd3);
    chk("rerun_halted", 32'(bus.id_halted), 32'd0);

    // load-use pair
    bus.instr_in = 32'h2140_0000;
    step();
    chk("ld_valid", 32'(bus.id_valid), 32'd1);
    chk("ld_class", 32'(bus.id_class), 32'd2);
    bus.instr_in = 32'h018A_0000;
    #1;
`ifdef HAZARD_DETECT_EN
    chk("hz_stall", 32'(bus.hazard_stall), 32'd1);
    step();
    chk("hz_bubble", 32'(bus.id_valid), 32'd0);
    chk("hz_release", 32'(bus.hazard_stall), 32'd0);
    step();
`else
    chk("hz_off", 32'(bus.hazard_stall), 32'd0);
    step();
`endif
    chk("use_valid", 32'(bus.id_valid), 32'd1);
    chk("use_rd",    32'(bus.id_rd), 32'd6);

    bus.instr_in = 32'h2000_0000;
    step();
    chk("ld0_valid", 32'(bus.id_valid), 32'd1);
    bus.instr_in = 32'h0180_0000;
    #1;
    chk("hz_rd0", 32'(bus.hazard_stall), 32'd0);
    step();
    chk("use0_valid", 32'(bus.id_valid), 32'd1);
    chk("use0_rd",    32'(bus.id_rd), 32'd6);

    // halt sequence
    bus.done_in  = 1'b1;
    bus.instr_in = 32'h5800_0000;
    step();
    chk("halt_bubble", 32'(bus.id_valid), 32'd0);
    chk("halt_early",  32'(bus.id_halted), 32'd0);
    bus.done_in  = 1'b0;
    bus.instr_in = 32'h00C2_2000;
    step();
    chk("halted",      32'(bus.id_halted), 32'd1);
    chk("halted_vld",  32'(bus.id_valid), 32'd0);
    bus.flush_in = 1'b1;
    step();
    chk("halted_hold", 32'(bus.id_halted), 32'd1);
    chk("halted_rd",   32'(bus.id_rd), 32'd6);
    bus.flush_in = 1'b0;
    step();
    chk("halted_ign",  32'(bus.id_valid), 32'd0);

    // asynchronous reset while halted
    #2;
    rst = 1'b1;
    #1;
    chk("arst_halted", 32'(bus.id_halted), 32'd0);
    chk("arst_rd",     32'(bus.id_rd), 32'd0);
    chk("arst_class",  32'(bus.id_class), 32'd6);
    rst = 1'b0;
    step();
    chk("post_valid",  32'(bus.id_valid), 32'd1);
    chk("post_rd",     32'(bus.id_rd), 32'd3);
    chk("post_halted", 32'(bus.id_halted), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
